// File: rtl/vga_arb_pkg.sv
// rtl/vga_arb_pkg.sv - shared types and constants for the display memory arbiter
//
// Purpose: state encoding, requester IDs (used as grant-vector bit indices)
// and default fairness parameters for vga_mem_arbiter.
package vga_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_XFER  = 2'd2
  } arb_state_e;

  // Bit positions inside the one-hot grant vector.
  localparam int REQ_CRT   = 0;
  localparam int REQ_CPUWR = 1;
  localparam int REQ_CPURD = 2;

  localparam int CRT_BURST_DEF  = 8;
  localparam int STARVE_LIM_DEF = 16;
  localparam int CNT_W_DEF      = 5;

  // One-hot mask for a requester ID.
  function automatic logic [2:0] req_mask(input int id);
    logic [2:0] m;
    m = '0;
    m[id[1:0]] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/vga_arb_satcnt.sv
// rtl/vga_arb_satcnt.sv - saturating up-counter with synchronous clear
//
// Purpose: counts up on inc, holds at all-ones, clears on clr (clr wins).
// Ports:
//   mem_clk    in   clock
//   h_reset_n  in   asynchronous active-low reset
//   clr        in   synchronous clear
//   inc        in   increment enable
//   cnt        out  current count (CNT_W bits)
module vga_arb_satcnt #(
  parameter int CNT_W = 5
) (
  input  logic             mem_clk,
  input  logic             h_reset_n,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge mem_clk or negedge h_reset_n) begin
    if (!h_reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/vga_mem_arbiter.sv
// rtl/vga_mem_arbiter.sv - display memory port arbiter (CRT refill / CPU write / CPU read)
//
// Purpose: picks one requester in IDLE, holds a one-hot grant while a single
// memory transaction runs through the req/ack/done handshake, and returns to
// IDLE (which doubles as the turnaround cycle). CRT bursts are capped while
// the CPU waits, and a long CPU wait forces CPU service unless CRT is urgent.
// Ports:
//   mem_clk, h_reset_n           clock, asynchronous active-low reset
//   crt_req, crt_urgent          CRT FIFO refill request / near-empty override
//   cpu_wr_req, cpu_rd_req       CPU write drain / CPU read requests
//   mem_ack, mem_done            memory controller accept / transfer-complete
//   mem_req                      request to memory controller (GRANT state)
//   crt_gnt, cpu_wr_gnt,
//   cpu_rd_gnt                   one-hot port ownership
//   arb_busy                     arbiter not in IDLE
//   starve_flag                  registered cpu_wait >= STARVE_LIM
module vga_mem_arbiter
  import vga_arb_pkg::*;
#(
  parameter int CRT_BURST  = CRT_BURST_DEF,
  parameter int STARVE_LIM = STARVE_LIM_DEF,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic mem_clk,
  input  logic h_reset_n,
  input  logic crt_req,
  input  logic crt_urgent,
  input  logic cpu_wr_req,
  input  logic cpu_rd_req,
  input  logic mem_ack,
  input  logic mem_done,
  output logic mem_req,
  output logic crt_gnt,
  output logic cpu_wr_gnt,
  output logic cpu_rd_gnt,
  output logic arb_busy,
  output logic starve_flag
);

  localparam logic [CNT_W-1:0] BURST_C  = CNT_W'(CRT_BURST);
  localparam logic [CNT_W-1:0] STARVE_C = CNT_W'(STARVE_LIM);
  localparam logic [2:0]       CPU_MASK = req_mask(REQ_CPUWR) | req_mask(REQ_CPURD);

  arb_state_e       state_q, state_d;
  logic [2:0]       gnt_q, gnt_d;
  logic             starve_q, starve_d;

  logic [CNT_W-1:0] crt_run;
  logic [CNT_W-1:0] cpu_wait;

  logic             cpu_pend;
  logic             any_req;
  logic [2:0]       cpu_pick;
  logic [2:0]       win;
  logic             issue;
  logic             cpu_issue;
  logic             crt_issue;

  assign cpu_pend = cpu_wr_req | cpu_rd_req;
  assign any_req  = crt_req | crt_urgent | cpu_pend;

  // Posted writes drain ahead of reads to keep CPU memory view coherent.
  assign cpu_pick = cpu_wr_req ? req_mask(REQ_CPUWR) : req_mask(REQ_CPURD);

  always_comb begin
    win = '0;
    if (crt_urgent) begin
      win = req_mask(REQ_CRT);
    end else if (cpu_pend && ((crt_run >= BURST_C) || (cpu_wait >= STARVE_C))) begin
      win = cpu_pick;
    end else if (crt_req) begin
      win = req_mask(REQ_CRT);
    end else if (cpu_pend) begin
      win = cpu_pick;
    end
  end

  assign issue     = (state_q == ST_IDLE) && any_req;
  assign cpu_issue = issue && ((win & CPU_MASK) != 3'b000);
  assign crt_issue = issue && win[REQ_CRT];

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          state_d = ST_GRANT;
          gnt_d   = win;
        end
      end
      ST_GRANT: begin
        // ack+done together skip XFER entirely.
        if (mem_ack) begin
          if (mem_done) begin
            state_d = ST_IDLE;
            gnt_d   = '0;
          end else begin
            state_d = ST_XFER;
          end
        end
      end
      ST_XFER: begin
        if (mem_done) begin
          state_d = ST_IDLE;
          gnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  assign starve_d = (cpu_wait >= STARVE_C);

  always_ff @(posedge mem_clk or negedge h_reset_n) begin
    if (!h_reset_n) begin
      state_q  <= ST_IDLE;
      gnt_q    <= '0;
      starve_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      starve_q <= starve_d;
    end
  end

  // CRT run length only matters while the CPU is waiting.
  vga_arb_satcnt #(.CNT_W(CNT_W)) u_crt_run (
    .mem_clk   (mem_clk),
    .h_reset_n (h_reset_n),
    .clr       (cpu_issue | ~cpu_pend),
    .inc       (crt_issue & cpu_pend),
    .cnt       (crt_run)
  );

  // Wait time accrues only while no CPU grant is held.
  vga_arb_satcnt #(.CNT_W(CNT_W)) u_cpu_wait (
    .mem_clk   (mem_clk),
    .h_reset_n (h_reset_n),
    .clr       (cpu_issue | ~cpu_pend),
    .inc       (cpu_pend & ((gnt_q & CPU_MASK) == 3'b000)),
    .cnt       (cpu_wait)
  );

  assign mem_req     = (state_q == ST_GRANT);
  assign arb_busy    = (state_q != ST_IDLE);
  assign crt_gnt     = gnt_q[REQ_CRT];
  assign cpu_wr_gnt  = gnt_q[REQ_CPUWR];
  assign cpu_rd_gnt  = gnt_q[REQ_CPURD];
  assign starve_flag = starve_q;

endmodule

// File: tb/tb_vga_mem_arbiter.sv
// tb/tb_vga_mem_arbiter.sv - self-checking bench for vga_mem_arbiter
module tb_vga_mem_arbiter;

  logic mem_clk = 1'b0;
  logic h_reset_n;
  logic crt_req, crt_urgent, cpu_wr_req, cpu_rd_req, mem_ack, mem_done;
  logic mem_req, crt_gnt, cpu_wr_gnt, cpu_rd_gnt, arb_busy, starve_flag;

  int checks = 0;
  int failures = 0;

  vga_mem_arbiter dut (
    .mem_clk     (mem_clk),
    .h_reset_n   (h_reset_n),
    .crt_req     (crt_req),
    .crt_urgent  (crt_urgent),
    .cpu_wr_req  (cpu_wr_req),
    .cpu_rd_req  (cpu_rd_req),
    .mem_ack     (mem_ack),
    .mem_done    (mem_done),
    .mem_req     (mem_req),
    .crt_gnt     (crt_gnt),
    .cpu_wr_gnt  (cpu_wr_gnt),
    .cpu_rd_gnt  (cpu_rd_gnt),
    .arb_busy    (arb_busy),
    .starve_flag (starve_flag)
  );

  always #5 mem_clk = ~mem_clk;

  // Output vector: {mem_req, crt_gnt, cpu_wr_gnt, cpu_rd_gnt, arb_busy, starve_flag}
  logic [5:0] outs;
  assign outs = {mem_req, crt_gnt, cpu_wr_gnt, cpu_rd_gnt, arb_busy, starve_flag};

  // Owner ID seen on the grant outputs: 0 none, 1 CRT, 2 write, 3 read.
  function automatic int gnt_id();
    if (crt_gnt)    return 1;
    if (cpu_wr_gnt) return 2;
    if (cpu_rd_gnt) return 3;
    return 0;
  endfunction

  task automatic cyc();
    @(posedge mem_clk);
    #1;
  endtask

  task automatic do_reset();
    crt_req = 0; crt_urgent = 0; cpu_wr_req = 0; cpu_rd_req = 0;
    mem_ack = 0; mem_done = 0;
    h_reset_n = 0;
    cyc();
    cyc();
    h_reset_n = 1;
  endtask

  // Zero-wait memory: accepts and completes in the first cycle mem_req is seen.
  task automatic respond();
    mem_ack  = mem_req;
    mem_done = mem_req;
  endtask

  // ---------------- reference model ----------------
  int  m_phase;   // 0 idle, 1 requesting, 2 transferring
  int  m_owner;   // 0 none, 1 CRT, 2 write, 3 read
  int  m_run, m_wait;
  bit  m_starve;

  task automatic model_reset();
    m_phase = 0; m_owner = 0; m_run = 0; m_wait = 0; m_starve = 0;
  endtask

  task automatic model_step();
    bit pend, held;
    int issued, nrun, nwait;
    pend = cpu_wr_req | cpu_rd_req;
    held = (m_owner >= 2);
    issued = 0;
    nrun = m_run;
    nwait = m_wait;
    m_starve = (m_wait >= 16);
    if (m_phase == 0) begin
      if (crt_req | crt_urgent | pend) begin
        if (crt_urgent) issued = 1;
        else if (pend && (m_run >= 8 || m_wait >= 16)) issued = cpu_wr_req ? 2 : 3;
        else if (crt_req) issued = 1;
        else issued = cpu_wr_req ? 2 : 3;
        m_owner = issued;
        m_phase = 1;
      end
    end else if (m_phase == 1) begin
      if (mem_ack) begin
        if (mem_done) begin m_phase = 0; m_owner = 0; end
        else m_phase = 2;
      end
    end else if (mem_done) begin
      m_phase = 0; m_owner = 0;
    end
    if (!pend || issued >= 2) nrun = 0;
    else if (issued == 1) nrun = (m_run + 1 > 31) ? 31 : m_run + 1;
    if (!pend || issued >= 2) nwait = 0;
    else if (!held) nwait = (m_wait + 1 > 31) ? 31 : m_wait + 1;
    m_run = nrun;
    m_wait = nwait;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    do_reset();
    checks++;
    if (outs !== 6'b000000) begin
      failures++;
      $display("FAIL reset_state: got %b want 000000", outs);
    end
    crt_req = 1;
    cyc();
    crt_req = 0;
    mem_ack = 1;
    cyc();
    mem_ack = 0;
    checks++;
    if (outs !== 6'b010010) begin
      failures++;
      $display("FAIL reset_pre_xfer: got %b want 010010", outs);
    end
    #2;
    h_reset_n = 0;
    #1;
    checks++;
    if (outs !== 6'b000000) begin
      failures++;
      $display("FAIL reset_async: got %b want 000000", outs);
    end
    cyc();
    h_reset_n = 1;
    cyc();
    checks++;
    if (outs !== 6'b000000) begin
      failures++;
      $display("FAIL reset_release_idle: got %b want 000000", outs);
    end
  endtask

  task automatic test_single_write();
    do_reset();
    cpu_wr_req = 1;                 // cycle 0
    cyc();                          // cycle 1
    checks++;
    if (outs !== 6'b101010) begin
      failures++;
      $display("FAIL single_c1: got %b want 101010", outs);
    end
    cyc();                          // cycle 2
    cyc();                          // cycle 3
    mem_ack = 1;
    cyc();                          // cycle 4
    mem_ack = 0;
    checks++;
    if (outs !== 6'b001010) begin
      failures++;
      $display("FAIL single_c4: got %b want 001010", outs);
    end
    cyc();                          // cycle 5
    cyc();                          // cycle 6
    checks++;
    if (outs !== 6'b001010) begin
      failures++;
      $display("FAIL single_c6: got %b want 001010", outs);
    end
    mem_done = 1;
    cyc();                          // cycle 7
    mem_done = 0;
    cpu_wr_req = 0;
    checks++;
    if (outs !== 6'b000000) begin
      failures++;
      $display("FAIL single_c7: got %b want 000000", outs);
    end
  endtask

  task automatic test_fairness();
    int seq[$];
    int prev, cur;
    do_reset();
    crt_req = 1;
    cpu_rd_req = 1;
    prev = 0;
    for (int c = 0; c < 300 && seq.size() < 18; c++) begin
      cyc();
      respond();
      cur = gnt_id();
      if (cur != 0 && prev == 0) seq.push_back(cur);
      prev = cur;
    end
    crt_req = 0; cpu_rd_req = 0; mem_ack = 0; mem_done = 0;
    checks++;
    if (seq.size() != 18) begin
      failures++;
      $display("FAIL fair_timeout: got %0d grants want 18", seq.size());
    end
    for (int i = 0; i < seq.size(); i++) begin
      int exp_id;
      exp_id = (i % 9 == 8) ? 3 : 1;
      checks++;
      if (seq[i] != exp_id) begin
        failures++;
        $display("FAIL fair_grant%0d: got id %0d want %0d", i, seq[i], exp_id);
      end
    end
    cyc();
  endtask

  task automatic test_urgent();
    int crt_cnt, cpu_cnt, prev, cur;
    do_reset();
    crt_urgent = 1;
    cpu_wr_req = 1;
    crt_cnt = 0; cpu_cnt = 0; prev = 0;
    for (int n = 1; n <= 40; n++) begin
      cyc();
      respond();
      cur = gnt_id();
      if (cur != 0 && prev == 0) begin
        if (cur == 1) crt_cnt++;
        else cpu_cnt++;
      end
      prev = cur;
      if (n == 16) begin
        checks++;
        if (starve_flag !== 1'b0) begin
          failures++;
          $display("FAIL urgent_starve_c16: got %b want 0", starve_flag);
        end
      end
      if (n == 17) begin
        checks++;
        if (starve_flag !== 1'b1) begin
          failures++;
          $display("FAIL urgent_starve_c17: got %b want 1", starve_flag);
        end
      end
    end
    checks++;
    if (crt_cnt != 20 || cpu_cnt != 0) begin
      failures++;
      $display("FAIL urgent_counts: got crt=%0d cpu=%0d want crt=20 cpu=0", crt_cnt, cpu_cnt);
    end
    crt_urgent = 0;
    cyc();                          // cycle 41
    respond();
    checks++;
    if (outs !== 6'b101011) begin
      failures++;
      $display("FAIL urgent_release_gnt: got %b want 101011", outs);
    end
    cyc();                          // cycle 42
    cpu_wr_req = 0;
    respond();
    checks++;
    if (outs !== 6'b000000) begin
      failures++;
      $display("FAIL urgent_starve_clear: got %b want 000000", outs);
    end
  endtask

  task automatic test_wr_before_rd();
    int seq[$];
    int prev, cur;
    do_reset();
    cpu_wr_req = 1;
    cpu_rd_req = 1;
    prev = 0;
    for (int c = 0; c < 50 && seq.size() < 2; c++) begin
      cyc();
      respond();
      cur = gnt_id();
      if (cur != 0 && prev == 0) begin
        seq.push_back(cur);
        if (cur == 2) cpu_wr_req = 0;
      end
      prev = cur;
    end
    cpu_wr_req = 0; cpu_rd_req = 0;
    checks++;
    if (seq.size() != 2 || seq[0] != 2 || seq[1] != 3) begin
      failures++;
      $display("FAIL wr_before_rd: got %0d grants first=%0d want 2 grants ids 2,3",
               seq.size(), (seq.size() > 0) ? seq[0] : 0);
    end
    cyc();
    respond();
  endtask

  task automatic test_back_to_back();
    do_reset();
    cpu_rd_req = 1;
    cyc();                          // cycle 1: GRANT
    mem_ack = 1; mem_done = 1;
    cyc();                          // cycle 2: IDLE, no XFER
    mem_ack = 0; mem_done = 0;
    checks++;
    if (outs !== 6'b000000) begin
      failures++;
      $display("FAIL combined_idle: got %b want 000000", outs);
    end
    cyc();                          // cycle 3: regranted
    checks++;
    if (outs !== 6'b100110) begin
      failures++;
      $display("FAIL combined_regrant: got %b want 100110", outs);
    end
    mem_done = 1;                   // done without ack must be ignored
    cyc();
    mem_done = 0;
    checks++;
    if (outs !== 6'b100110) begin
      failures++;
      $display("FAIL stray_done: got %b want 100110", outs);
    end
    mem_ack = 1;
    cyc();                          // XFER
    checks++;
    if (outs !== 6'b000110) begin
      failures++;
      $display("FAIL xfer_entry: got %b want 000110", outs);
    end
    cyc();                          // ack in XFER must be ignored
    mem_ack = 0;
    checks++;
    if (outs !== 6'b000110) begin
      failures++;
      $display("FAIL stray_ack: got %b want 000110", outs);
    end
    cpu_rd_req = 0;
    mem_done = 1;
    cyc();
    mem_done = 0;
    checks++;
    if (outs !== 6'b000000) begin
      failures++;
      $display("FAIL xfer_done: got %b want 000000", outs);
    end
  endtask

  task automatic test_random();
    logic [5:0] exp;
    int bad;
    do_reset();
    model_reset();
    bad = 0;
    for (int c = 0; c < 800; c++) begin
      crt_req    = ($urandom_range(0, 2) != 0);
      crt_urgent = ($urandom_range(0, 9) == 0);
      cpu_wr_req = ($urandom_range(0, 2) == 0);
      cpu_rd_req = ($urandom_range(0, 1) == 0);
      mem_ack    = ($urandom_range(0, 2) == 0);
      mem_done   = ($urandom_range(0, 2) == 0);
      model_step();
      cyc();
      exp = {m_phase == 1, m_owner == 1, m_owner == 2, m_owner == 3, m_phase != 0, m_starve};
      checks++;
      if (outs !== exp) begin
        failures++;
        bad++;
        if (bad <= 10) $display("FAIL random_c%0d: got %b want %b", c, outs, exp);
      end
    end
    crt_req = 0; crt_urgent = 0; cpu_wr_req = 0; cpu_rd_req = 0;
    mem_ack = 0; mem_done = 0;
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_fairness();
    test_urgent();
    test_wr_before_rd();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vga_mem_arbiter.md
Name: vga_mem_arbiter

Overview:
- Arbitrates the shared external display memory port among three requesters:
  - CRT display-FIFO refill.
  - CPU write drain, from the CPU FIFO / CPU cycle state machine.
  - CPU read.
- Issues one-hot grants (cpu_rd_gnt feeds the CPU cycle sequencer) and sequences a single memory transaction at a time through a request/ack/done handshake.
- Bounds CPU starvation while keeping urgent display refill absolute.

Parameters:
- CRT_BURST, 8: max consecutive CRT grants while any CPU request is pending.
- STARVE_LIM, 16: cycles a pending CPU request may wait before forced service.
- CNT_W, 5: width of the burst and wait counters; must hold max(CRT_BURST, STARVE_LIM).

Ports:
- mem_clk  in  1  clock.
- h_reset_n  in  1  reset, asynchronous, active-low.
- crt_req  in  1  CRT FIFO below refill watermark; level, held until granted.
- crt_urgent  in  1  CRT FIFO near empty; overrides all fairness.
- cpu_wr_req  in  1  CPU write FIFO non-empty; level.
- cpu_rd_req  in  1  CPU read pending; level.
- mem_ack  in  1  memory controller accepted the current request.
- mem_done  in  1  current transfer complete; 1-cycle pulse.
- mem_req  out  1  request to memory controller.
- crt_gnt  out  1  CRT owns the port.
- cpu_wr_gnt  out  1  CPU write owns the port.
- cpu_rd_gnt  out  1  CPU read owns the port.
- arb_busy  out  1  not in IDLE.
- starve_flag  out  1  cpu_wait >= STARVE_LIM.

Behaviour:
- Reset: FSM = IDLE; all grants, mem_req, arb_busy, starve_flag = 0; crt_run = 0; cpu_wait = 0. An asynchronous reset mid-transaction aborts immediately. No outstanding state is retained.
- FSM states:
  - IDLE -> GRANT when any request is asserted. The winner is registered, so grant and mem_req rise 1 cycle after the request is sampled.
  - GRANT: mem_req = 1. -> XFER on mem_ack. If mem_ack and mem_done arrive in the same cycle, -> IDLE directly.
  - XFER: mem_req = 0. -> IDLE on mem_done.
  - IDLE also serves as the mandatory 1-cycle turnaround. Back-to-back grants are therefore spaced by at least 1 idle cycle.
- Grants: one-hot, valid from GRANT entry through the cycle mem_done is seen, and deasserted on the next edge. Grants never change during GRANT or XFER, even if requests drop.
- Priority, evaluated in IDLE only:
  1. crt_urgent -> CRT.
  2. Otherwise, if a CPU request is pending and (crt_run >= CRT_BURST or cpu_wait >= STARVE_LIM) -> CPU.
  3. Otherwise crt_req -> CRT.
  4. Otherwise CPU.
- Within CPU, cpu_wr_req beats cpu_rd_req, so posted writes drain before reads for coherency.
- crt_run:
  - +1 on each CRT grant while any CPU request is pending.
  - Cleared on any CPU grant, or in any cycle with no CPU request pending.
  - Saturates at 2^CNT_W-1.
- cpu_wait:
  - +1 each cycle a CPU request is pending and no CPU grant is held.
  - Cleared when a CPU grant is issued, or when no CPU request is pending.
  - Saturates.
- starve_flag is registered from cpu_wait.
- crt_urgent beats forced CPU service, so starve_flag may stay high. Starvation during urgent refill is tolerated by design.
- A mem_done seen while not in XFER (or GRANT with ack) is ignored. A mem_ack seen outside GRANT is ignored.

Decomposition:
- Package vga_arb_pkg holds:
  - The state encoding (IDLE/GRANT/XFER, 2-bit).
  - Requester ID constants (REQ_CRT, REQ_CPUWR, REQ_CPURD).
  - Default CRT_BURST and STARVE_LIM values.
- Sub-module vga_arb_satcnt: a saturating up-counter with synchronous clear and increment enable, width CNT_W. It is instantiated twice, for crt_run and cpu_wait.

Test Plan:
1. Reset: h_reset_n low during XFER with crt_gnt = 1 -> all outputs 0 asynchronously. After release, FSM is IDLE and counters are 0.
2. Single write: cpu_wr_req = 1 at cycle 0 -> cpu_wr_gnt and mem_req = 1 at cycle 1. mem_ack at cycle 3 -> mem_req = 0 at cycle 4. mem_done at cycle 6 -> cpu_wr_gnt = 0 at cycle 7.
3. Fairness: crt_req and cpu_rd_req held high, mem_ack and mem_done with 1-cycle latency -> exactly 8 CRT grants, then 1 cpu_rd_gnt, repeating.
4. Urgent override: crt_urgent held high with cpu_wr_req high for 40 cycles -> only crt_gnt issued; starve_flag = 1 from cycle 17. Drop crt_urgent -> next grant is cpu_wr_gnt and starve_flag clears.
5. Write-before-read: cpu_wr_req and cpu_rd_req rise together -> cpu_wr_gnt first; cpu_rd_gnt on the following arbitration.
6. Combined handshake: mem_ack and mem_done in the same cycle -> FSM returns to IDLE. The next pending request is granted 2 cycles later; there is no extra XFER cycle.
